md5_search_ctrl: RTL

- Parametrised successor to the single-channel brute-force driver. Sequences candidate generation for NUM_CH parallel MD5 pipelines and tracks their fixed latency in a delay line.
- Recovers the exact candidate behind any pipeline match and exposes paused/running/warming/found/done status.
- Sits between the VIO/switch control layer and the MD5 pipeline array.

---
 rtl/md5_search_pkg.sv | 40 ++++
 rtl/md5_search_dline.sv | 58 +++++
 rtl/md5_search_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/md5_search_pkg.sv
// Shared types and helpers for the MD5 brute-force search controller.
package md5_search_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WARMING,
        RUNNING,
        PAUSED,
        FOUND,
        DONE
    } state_t;

    // Width of the optional busy-cycle counter.
    localparam int PERF_W = 48;

    // Ceiling log2; clog2(1) = 0 so a single-channel build has no index bits.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Index of the lowest set bit; the lowest channel wins on multiple hits.
    function automatic logic [3:0] lowest_set_index(input logic [15:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/md5_search_dline.sv
// Delay line mirroring the MD5 pipeline depth: tracks {valid, base} for every
// issued base so the head entry lines up with the pipeline match flags.
module md5_search_dline
    import md5_search_pkg::*;
#(
    parameter int LATENCY = 64,
    parameter int BASE_W  = 30,
    parameter int IF_W    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push_valid,
    input  logic [BASE_W-1:0] push_base,
    output logic              head_valid,
    output logic [BASE_W-1:0] head_base,
    output logic [IF_W-1:0]   inflight
);

    logic [LATENCY-1:0] valid_reg;
    logic [BASE_W-1:0]  base_reg [LATENCY];
    logic [IF_W-1:0]    inflight_reg;

    // Valid bits shift every cycle; a flush drops everything including the new entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (flush) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= {valid_reg[LATENCY-2:0], push_valid};
        end
    end

    // Base payload needs no reset: it is only trusted alongside its valid bit.
    always_ff @(posedge clk) begin
        base_reg[0] <= push_base;
        for (int i = 1; i < LATENCY; i++) begin
            base_reg[i] <= base_reg[i-1];
        end
    end

    // Number of valid entries currently in the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_reg <= '0;
        end else if (flush) begin
            inflight_reg <= '0;
        end else begin
            inflight_reg <= inflight_reg + IF_W'(push_valid) - IF_W'(valid_reg[LATENCY-1]);
        end
    end

    assign head_valid = valid_reg[LATENCY-1];
    assign head_base  = base_reg[LATENCY-1];
    assign inflight   = inflight_reg;

endmodule

// File: rtl/md5_search_ctrl.sv
// Candidate sequencer for NUM_CH parallel MD5 pipelines. Issues one base per
// cycle, tracks the pipeline latency, recovers the matching candidate and
// reports paused/running/warming/found/done status.
// Optional MD5_SEARCH_PERF_EN adds perf_cycles / perf_paused counters.
module md5_search_ctrl
    import md5_search_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int LATENCY  = 64,
    parameter int DIGEST_W = 128,
    localparam int IDX_W   = clog2(NUM_CH),
    localparam int BASE_W  = CNT_W - IDX_W
) (
    input  logic                CLK,
    input  logic                CPU_RESET,
    input  logic                enable,
    input  logic                clear,
    input  logic [DIGEST_W-1:0] target_selected,
    input  logic [NUM_CH-1:0]   match_vec,
    output logic [DIGEST_W-1:0] target_digest,
    output logic [BASE_W-1:0]   cand_base,
    output logic                cand_valid,
    output logic [CNT_W-1:0]    found_cand,
    output logic                status_paused,
    output logic                status_running,
    output logic                status_warming,
    output logic                status_found,
    output logic                status_done
`ifdef MD5_SEARCH_PERF_EN
    ,
    output logic [PERF_W-1:0]   perf_cycles,
    output logic [31:0]         perf_paused
`endif
);

    localparam int WC_W = clog2(LATENCY + 1);

    state_t              state_reg, state_next;
    logic [WC_W-1:0]     warm_cnt_reg, warm_cnt_next;
    logic                last_issued_reg, last_issued_next;
    logic [BASE_W-1:0]   cand_base_reg;
    logic                cand_valid_reg;
    logic [CNT_W-1:0]    found_cand_reg;
    logic [DIGEST_W-1:0] target_digest_reg;
    logic [4:0]          status_reg;

    logic                head_valid;
    logic [BASE_W-1:0]   head_base;
    logic [WC_W-1:0]     inflight;
    logic                head_hit;
    logic                drained;
    logic                searching;
    logic [CNT_W-1:0]    hit_cand;

    md5_search_dline #(
        .LATENCY (LATENCY),
        .BASE_W  (BASE_W),
        .IF_W    (WC_W)
    ) u_dline (
        .clk        (CLK),
        .rst        (CPU_RESET),
        .flush      (clear),
        .push_valid (cand_valid_reg),
        .push_base  (cand_base_reg),
        .head_valid (head_valid),
        .head_base  (head_base),
        .inflight   (inflight)
    );

    // Next-state decode: match beats drain-complete, which beats enable handling.
    always_comb begin
        head_hit  = head_valid && (match_vec != '0);
        // The last valid entry leaves the line on this edge.
        drained   = last_issued_reg && (inflight == WC_W'(head_valid));
        searching = (state_reg == WARMING) || (state_reg == RUNNING) || (state_reg == PAUSED);
        hit_cand  = (CNT_W'(head_base) << IDX_W) | CNT_W'(lowest_set_index(16'(match_vec)));

        warm_cnt_next = warm_cnt_reg;
        if (cand_valid_reg && (warm_cnt_reg < WC_W'(LATENCY))) begin
            warm_cnt_next = warm_cnt_reg + WC_W'(1);
        end
        last_issued_next = last_issued_reg | (cand_valid_reg & (&cand_base_reg));

        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = WARMING;
                end
            end
            WARMING, RUNNING, PAUSED: begin
                if (head_hit) begin
                    state_next = FOUND;
                end else if (drained) begin
                    state_next = DONE;
                end else if ((state_reg != PAUSED) && !enable) begin
                    state_next = PAUSED;
                end else if ((state_reg != PAUSED) || enable) begin
                    state_next = (warm_cnt_next >= WC_W'(LATENCY)) ? RUNNING : WARMING;
                end
            end
            default: state_next = state_reg;
        endcase
    end

    // FSM state plus every registered output; clear overrides all but target_digest.
    always_ff @(posedge CLK or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            state_reg         <= IDLE;
            warm_cnt_reg      <= '0;
            last_issued_reg   <= 1'b0;
            cand_base_reg     <= '0;
            cand_valid_reg    <= 1'b0;
            found_cand_reg    <= '0;
            target_digest_reg <= '0;
            status_reg        <= '0;
        end else if (clear) begin
            state_reg       <= IDLE;
            warm_cnt_reg    <= '0;
            last_issued_reg <= 1'b0;
            cand_base_reg   <= '0;
            cand_valid_reg  <= 1'b0;
            found_cand_reg  <= '0;
            status_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            warm_cnt_reg    <= warm_cnt_next;
            last_issued_reg <= last_issued_next;
            if (cand_valid_reg) begin
                cand_base_reg <= cand_base_reg + BASE_W'(1);
            end
            cand_valid_reg <= ((state_next == WARMING) || (state_next == RUNNING)) && !last_issued_next;
            if ((state_reg == IDLE) && enable) begin
                target_digest_reg <= target_selected;
            end
            if (searching && head_hit) begin
                found_cand_reg <= hit_cand;
            end
            status_reg <= {state_next == PAUSED, state_next == RUNNING, state_next == WARMING,
                           state_next == FOUND, state_next == DONE};
        end
    end

    assign target_digest  = target_digest_reg;
    assign cand_base      = cand_base_reg;
    assign cand_valid     = cand_valid_reg;
    assign found_cand     = found_cand_reg;
    assign status_paused  = status_reg[4];
    assign status_running = status_reg[3];
    assign status_warming = status_reg[2];
    assign status_found   = status_reg[1];
    assign status_done    = status_reg[0];

`ifdef MD5_SEARCH_PERF_EN
    logic [PERF_W-1:0] perf_cycles_reg;
    logic [31:0]       perf_paused_reg;

    // Saturating cycle counters for busy (warming/running) and paused time.
    always_ff @(posedge CLK or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            perf_cycles_reg <= '0;
            perf_paused_reg <= '0;
        end else if (clear) begin
            perf_cycles_reg <= '0;
            perf_paused_reg <= '0;
        end else begin
            if (((state_reg == WARMING) || (state_reg == RUNNING)) && (perf_cycles_reg != '1)) begin
                perf_cycles_reg <= perf_cycles_reg + PERF_W'(1);
            end
            if ((state_reg == PAUSED) && (perf_paused_reg != '1)) begin
                perf_paused_reg <= perf_paused_reg + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_reg;
    assign perf_paused = perf_paused_reg;
`endif

endmodule
